// File: rtl/pwm_duty_ramper.sv
// pwm_duty_ramper: per-channel target duties, slewed toward by a tick-driven scan of live duties
module pwm_duty_ramper #(
  parameter int NPWM = 5,
  parameter int Resolution = 8,
  parameter int TickDiv = 100000,
  parameter int Step = 1,
  localparam int CW = NPWM > 1 ? $clog2(NPWM) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CW-1:0]                wr_chan,
  input  logic [Resolution-1:0]        wr_duty,
  input  logic                         wr_immediate,
  output logic [NPWM*Resolution-1:0]   DC_bus,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err
);
  localparam int PW = $clog2(TickDiv);
  localparam logic [PW-1:0] CMAX = PW'(TickDiv - 1);
  localparam logic [CW:0] NP = (CW + 1)'(NPWM);
  localparam logic [CW-1:0] LAST = CW'(NPWM - 1);
  localparam logic [Resolution-1:0] SR = Resolution'(Step);
  localparam logic [Resolution:0] SW = (Resolution + 1)'(Step);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_d;
  logic [PW-1:0] cnt;
  logic [CW-1:0] idx, idx_d;
  logic [NPWM-1:0] diff;
  logic tick, acc;
  assign tick = enable && cnt == CMAX;
  assign wr_ready = state == IDLE;
  assign acc = wr_valid && wr_ready;
  always_comb begin
    state_d = state == IDLE ? (tick ? SCAN : IDLE) : (idx == LAST ? IDLE : SCAN);
    idx_d = state == SCAN && idx != LAST ? idx + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      cnt <= !enable || cnt == CMAX ? '0 : cnt + 1'b1;
      busy <= |diff;
      done <= busy && !(|diff);
      wr_err <= acc && !({1'b0, wr_chan} < NP);
    end
  for (genvar k = 0; k < NPWM; k++) begin : g_ch
    logic [Resolution-1:0] tgt, lv, nxt;
    logic [Resolution:0] d;
    logic up;
    always_comb begin
      up = tgt > lv;
      d = up ? {1'b0, tgt} - {1'b0, lv} : {1'b0, lv} - {1'b0, tgt};
      nxt = d <= SW ? tgt : up ? lv + SR : lv - SR;
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        tgt <= '0;
        lv <= '0;
      end else if (acc && wr_chan == CW'(k)) begin
        tgt <= wr_duty;
        if (wr_immediate) lv <= wr_duty;
      end else if (state == SCAN && idx == CW'(k)) begin
        lv <= nxt;
      end
    assign DC_bus[k*Resolution +: Resolution] = lv;
    assign diff[k] = tgt != lv;
  end
endmodule

// File: tb/tb_pwm_duty_ramper.sv
// tb_pwm_duty_ramper: directed checks of ramping, handshake, freeze and reset on Step=1 and Step=4 instances
module tb_pwm_duty_ramper;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, wr_valid = 1'b0, wr_immediate = 1'b0;
  logic [2:0] wr_chan = '0;
  logic [7:0] wr_duty = '0;
  logic rdy1, rdy4, busy1, busy4, done1, done4, err1, err4;
  logic [39:0] dc1, dc4, snap;
  int tests = 0, fails = 0, j = 0, w = 0;
  logic pulses;
  always #5 clk = ~clk;
  pwm_duty_ramper #(.NPWM(5), .Resolution(8), .TickDiv(16), .Step(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid), .wr_ready(rdy1),
    .wr_chan(wr_chan), .wr_duty(wr_duty), .wr_immediate(wr_immediate),
    .DC_bus(dc1), .busy(busy1), .done(done1), .wr_err(err1));
  pwm_duty_ramper #(.NPWM(5), .Resolution(8), .TickDiv(16), .Step(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid), .wr_ready(rdy4),
    .wr_chan(wr_chan), .wr_duty(wr_duty), .wr_immediate(wr_immediate),
    .DC_bus(dc4), .busy(busy4), .done(done4), .wr_err(err4));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    j++;
  endtask
  task automatic to(input int t);
    while (j < t) step();
  endtask
  task automatic go();
    enable = 1'b1;
    j = 0;
  endtask
  task automatic rst_all();
    reset = 1'b0;
    enable = 1'b0;
    wr_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask
  task automatic wr(input logic [2:0] ch, input logic [7:0] duty, input logic imm, output int waits);
    wr_valid = 1'b1;
    wr_chan = ch;
    wr_duty = duty;
    wr_immediate = imm;
    waits = 0;
    while (!rdy1 && waits < 100) begin
      step();
      waits++;
    end
    if (waits >= 100) chk("wr_timeout", rdy1, 1);
    step();
    wr_valid = 1'b0;
    wr_immediate = 1'b0;
  endtask
  initial begin
    step();
    chk("rst_dc", dc1, 0);
    chk("rst_ready", rdy1, 1);
    chk("rst_busy", busy1, 0);
    reset = 1'b1;
    step();
    go();
    pulses = 1'b0;
    repeat (40) begin
      step();
      pulses = pulses | done1 | err1 | done4 | err4;
    end
    chk("rst_quiet", pulses, 0);
    chk("rst_dc_idle", dc1, 0);
    rst_all();
    wr(3'd2, 8'd3, 1'b0, w);
    chk("busy_lat", busy1, 0);
    step();
    chk("busy_up", busy1, 1);
    go();
    to(18); chk("ch2_pre", dc1[16 +: 8], 0);
    to(19); chk("ch2_t1", dc1[16 +: 8], 1);
    to(35); chk("ch2_t2", dc1[16 +: 8], 2);
    to(51); chk("ch2_t3", dc1[16 +: 8], 3);
    chk("done_early", done1, 0);
    to(52); chk("done_pulse", done1, 1);
    chk("busy_fall", busy1, 0);
    to(53); chk("done_once", done1, 0);
    chk("others_zero", dc1 & 40'hFF_FF00_FFFF, 0);
    rst_all();
    wr(3'd0, 8'd10, 1'b0, w);
    go();
    to(16); chk("s4_pre", dc4[0 +: 8], 0);
    to(17); chk("s4_up1", dc4[0 +: 8], 4);
    to(33); chk("s4_up2", dc4[0 +: 8], 8);
    to(49); chk("s4_clamp", dc4[0 +: 8], 10);
    to(65); chk("s4_hold", dc4[0 +: 8], 10);
    enable = 1'b0;
    wr(3'd0, 8'd0, 1'b0, w);
    go();
    to(17); chk("s4_dn1", dc4[0 +: 8], 6);
    to(33); chk("s4_dn2", dc4[0 +: 8], 2);
    to(49); chk("s4_floor", dc4[0 +: 8], 0);
    to(65); chk("s4_nowrap", dc4[0 +: 8], 0);
    rst_all();
    wr(3'd4, 8'd220, 1'b1, w);
    chk("imm_dc", dc1[32 +: 8], 220);
    pulses = 1'b0;
    repeat (3) begin
      step();
      pulses = pulses | done1 | busy1;
    end
    chk("imm_quiet", pulses, 0);
    wr(3'd1, 8'd5, 1'b0, w);
    step();
    chk("imm_busy", busy1, 1);
    wr(3'd4, 8'd200, 1'b1, w);
    chk("imm_dc2", dc1[32 +: 8], 200);
    step();
    chk("imm_still_busy", busy1, 1);
    chk("imm_no_done", done1, 0);
    go();
    to(82); chk("done_wait", done1, 0);
    chk("ch1_final", dc1[8 +: 8], 5);
    to(83); chk("done_other", done1, 1);
    rst_all();
    go();
    to(15); chk("hs_ready_pre", rdy1, 1);
    to(16);
    wr(3'd3, 8'd7, 1'b0, w);
    chk("hs_ready_low", w, 5);
    chk("hs_no_err", err1, 0);
    to(23); chk("hs_busy", busy1, 1);
    to(36); chk("hs_ch3", dc1[24 +: 8], 1);
    chk("hs_ch3_s4", dc4[24 +: 8], 4);
    to(40);
    snap = dc1;
    wr(3'd6, 8'd99, 1'b1, w);
    chk("err_pulse", err1, 1);
    step();
    chk("err_once", err1, 0);
    chk("err_dc", dc1, snap);
    rst_all();
    wr(3'd1, 8'd200, 1'b0, w);
    go();
    to(18); chk("fr_t1", dc1[8 +: 8], 1);
    to(34); chk("fr_t2", dc1[8 +: 8], 2);
    to(40);
    enable = 1'b0;
    to(100); chk("fr_hold", dc1[8 +: 8], 2);
    go();
    to(17); chk("fr_still", dc1[8 +: 8], 2);
    to(18); chk("fr_resume", dc1[8 +: 8], 3);
    to(33);
    chk("mid_busy", busy1, 1);
    chk("mid_ready", rdy1, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_dc", {dc1, dc4}, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_ready", rdy1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
